// File: rtl/controle_multiciclo.sv
// Multicycle control FSM for the RV64I-subset datapath.
// Sequences fetch/decode/execute, memory handshake, halt and retire count.
module controle_multiciclo #(
  parameter int CNT_WIDTH   = 64,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7_5,
  input  logic                 zero,
  input  logic                 dmem_ack,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 ir_write,
  output logic                 pc_old_write,
  output logic                 ab_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 alu_out_write,
  output logic                 dmem_read,
  output logic                 dmem_write,
  output logic                 mdr_write,
  output logic                 reg_write,
  output logic [1:0]           mem_to_reg,
  output logic                 halted,
  output logic [1:0]           err,
  output logic [3:0]           state_out,
  output logic [CNT_WIDTH-1:0] instret
);

  localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    LUI      = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    MEM_WR   = 4'd7,
    MEM_WB   = 4'd8,
    ALU_WB   = 4'd9,
    BRANCH   = 4'd10,
    JAL      = 4'd11,
    HALT     = 4'd12
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           err_q, err_d;
  logic [WW-1:0]        wait_q, wait_d;
  logic [CNT_WIDTH-1:0] instret_q;
  logic                 retire;

  logic is_r, is_i, is_lui, is_ld, is_sd, is_br, is_jal, is_ebrk;

  assign is_r    = (opcode == 7'b0110011) && (funct3 == 3'b000);
  assign is_i    = (opcode == 7'b0010011) && (funct3 == 3'b000);
  assign is_lui  = (opcode == 7'b0110111);
  assign is_ld   = (opcode == 7'b0000011) && (funct3 == 3'b011);
  assign is_sd   = (opcode == 7'b0100011) && (funct3 == 3'b011);
  assign is_br   = (opcode == 7'b1100011) && (funct3[2:1] == 2'b00);
  assign is_jal  = (opcode == 7'b1101111);
  assign is_ebrk = (opcode == 7'b1110011);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      err_q     <= 2'd0;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
      if (retire)
        instret_q <= instret_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    err_d         = err_q;
    wait_d        = '0;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    ir_write      = 1'b0;
    pc_old_write  = 1'b0;
    ab_write      = 1'b0;
    alu_src_a     = 2'd0;
    alu_src_b     = 2'd0;
    alu_op        = 2'd0;
    alu_out_write = 1'b0;
    dmem_read     = 1'b0;
    dmem_write    = 1'b0;
    mdr_write     = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 2'd0;
    halted        = 1'b0;
    unique case (state_q)
      FETCH: begin
        ir_write     = 1'b1;
        pc_old_write = 1'b1;
        pc_write     = 1'b1;
        alu_src_b    = 2'd1;
        state_d      = DECODE;
      end
      DECODE: begin
        ab_write      = 1'b1;
        alu_out_write = 1'b1;
        alu_src_a     = 2'd2;
        alu_src_b     = 2'd2;
        unique case (1'b1)
          is_r:          state_d = EXEC_R;
          is_i:          state_d = EXEC_I;
          is_lui:        state_d = LUI;
          is_ld, is_sd:  state_d = MEM_ADDR;
          is_br:         state_d = BRANCH;
          is_jal:        state_d = JAL;
          is_ebrk:       state_d = HALT;
          default: begin
            state_d = HALT;
            err_d   = 2'd1;
          end
        endcase
      end
      EXEC_R: begin
        alu_src_a     = 2'd1;
        alu_op        = funct7_5 ? 2'd1 : 2'd0;
        alu_out_write = 1'b1;
        state_d       = ALU_WB;
      end
      EXEC_I: begin
        alu_src_a     = 2'd1;
        alu_src_b     = 2'd2;
        alu_out_write = 1'b1;
        state_d       = ALU_WB;
      end
      LUI: begin
        alu_src_b     = 2'd2;
        alu_op        = 2'd2;
        alu_out_write = 1'b1;
        state_d       = ALU_WB;
      end
      ALU_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      MEM_ADDR: begin
        alu_src_a     = 2'd1;
        alu_src_b     = 2'd2;
        alu_out_write = 1'b1;
        state_d       = (opcode == 7'b0000011) ? MEM_RD : MEM_WR;
      end
      MEM_RD, MEM_WR: begin
        dmem_read  = (state_q == MEM_RD);
        dmem_write = (state_q == MEM_WR);
        // ack in the last allowed cycle still completes normally
        if (dmem_ack) begin
          mdr_write = (state_q == MEM_RD);
          retire    = (state_q == MEM_WR);
          state_d   = (state_q == MEM_RD) ? MEM_WB : FETCH;
        end else if (wait_q == WAIT_MAX) begin
          state_d = HALT;
          err_d   = 2'd2;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd1;
        retire     = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        alu_src_a = 2'd1;
        alu_op    = 2'd1;
        if ((funct3 == 3'b000 && zero) || (funct3 == 3'b001 && !zero)) begin
          pc_write = 1'b1;
          pc_src   = 1'b1;
        end
        retire  = 1'b1;
        state_d = FETCH;
      end
      JAL: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd2;
        pc_write   = 1'b1;
        pc_src     = 1'b1;
        retire     = 1'b1;
        state_d    = FETCH;
      end
      HALT: halted = 1'b1;
      default: state_d = HALT;
    endcase
    if (rst) begin
      pc_write      = 1'b0;
      pc_src        = 1'b0;
      ir_write      = 1'b0;
      pc_old_write  = 1'b0;
      ab_write      = 1'b0;
      alu_src_a     = 2'd0;
      alu_src_b     = 2'd0;
      alu_op        = 2'd0;
      alu_out_write = 1'b0;
      dmem_read     = 1'b0;
      dmem_write    = 1'b0;
      mdr_write     = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 2'd0;
      halted        = 1'b0;
    end
  end

  assign err       = err_q;
  assign state_out = state_q;
  assign instret   = instret_q;

endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
- Multicycle control FSM that sequences the 64-bit RV64I-subset datapath inside `unidadeProcessamento`.
- It drives the write enables for PC, IR, register file, A/B, ALUOut and MDR, plus the mux selects and the data-memory request/ack handshake.
- Opcode and funct fields come from the registered IR; the zero flag comes from the ALU.
- It halts on ebreak, illegal encoding or memory timeout, and keeps a retired-instruction counter.

Parameters:
- CNT_WIDTH, 64, width of `instret` counter.
- MEM_TIMEOUT, 255, maximum cycles a data-memory request may wait for `dmem_ack` before error halt.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7_5  in  1  IR[30]
- zero  in  1  ALU result == 0 (combinational, same cycle)
- dmem_ack  in  1  data memory completed current read/write
- pc_write  out  1  load PC
- pc_src  out  1  0 = ALU result, 1 = ALUOut
- ir_write  out  1  load IR (instruction memory is single-cycle)
- pc_old_write  out  1  save current PC
- ab_write  out  1  load A/B from register file
- alu_src_a  out  2  0 = PC, 1 = A, 2 = PC_old
- alu_src_b  out  2  0 = B, 1 = const 4, 2 = imm
- alu_op  out  2  0 = ADD, 1 = SUB, 2 = PASS_B
- alu_out_write  out  1  load ALUOut
- dmem_read  out  1  data read request
- dmem_write  out  1  data write request
- mdr_write  out  1  load MDR
- reg_write  out  1  register file write
- mem_to_reg  out  2  0 = ALUOut, 1 = MDR, 2 = PC (link)
- halted  out  1  FSM in HALT
- err  out  2  0 none, 1 illegal instr, 2 mem timeout; sticky until rst
- state_out  out  4  current state encoding
- instret  out  CNT_WIDTH  retired instruction count

Behaviour:
- State encoding:
  - FETCH = 0, DECODE = 1, EXEC_R = 2, EXEC_I = 3, LUI = 4, MEM_ADDR = 5, MEM_RD = 6, MEM_WR = 7, MEM_WB = 8, ALU_WB = 9, BRANCH = 10, JAL = 11, HALT = 12.
- Reset:
  - `rst` high at a clock edge sets state = FETCH, `err` = 0, `instret` = 0, wait counter = 0.
  - All control outputs are forced to 0 while `rst` is high, including `pc_write` and `ir_write`.
  - The first FETCH is the first cycle with `rst` low.
  - Reset mid-instruction or mid-handshake aborts immediately; no write enable is asserted in that cycle.
- Outputs are Moore, decoded from state. Exceptions: BRANCH `pc_write`, the MEM_RD/MEM_WR ack handling, and the opcode-dependent next-state logic are Mealy. Unlisted outputs are 0.
- FETCH:
  - `ir_write`, `pc_old_write`, `pc_write`, pc_src = 0, a = 0, b = 1, ADD.
  - Next state DECODE.
- DECODE:
  - `ab_write`, `alu_out_write`, a = 2, b = 2, ADD (ALUOut = branch/jal target).
  - Next-state dispatch:
    - 0110011 with funct3 = 000 → EXEC_R
    - 0010011 with funct3 = 000 → EXEC_I
    - 0110111 → LUI
    - 0000011 with funct3 = 011 → MEM_ADDR (ld)
    - 0100011 with funct3 = 011 → MEM_ADDR (sd)
    - 1100011 with funct3 000/001 → BRANCH
    - 1101111 → JAL
    - 1110011 → HALT with `err` unchanged (ebreak)
    - anything else → HALT with `err` = 1
- EXEC_R: a = 1, b = 0, alu_op = funct7_5 ? SUB : ADD, `alu_out_write`; → ALU_WB.
- EXEC_I: a = 1, b = 2, ADD, `alu_out_write`; → ALU_WB.
- LUI: b = 2, PASS_B, `alu_out_write`; → ALU_WB.
- ALU_WB: `reg_write`, mem_to_reg = 0; → FETCH.
- MEM_ADDR: a = 1, b = 2, ADD, `alu_out_write`; → MEM_RD if opcode = 0000011, else MEM_WR.
- MEM_RD:
  - `dmem_read` held high until `dmem_ack`.
  - In the ack cycle `mdr_write` = 1, then → MEM_WB.
- MEM_WB: `reg_write`, mem_to_reg = 1; → FETCH.
- MEM_WR: `dmem_write` held high until `dmem_ack`; → FETCH.
- Memory wait timeout (MEM_RD and MEM_WR):
  - Wait counter clears on entering the state and increments each cycle without ack.
  - If `dmem_ack` = 0 and counter = MEM_TIMEOUT-1 → HALT with `err` = 2.
  - Ack arriving in that same cycle wins (normal completion, no error).
  - The maximum total request length is therefore MEM_TIMEOUT cycles.
- BRANCH:
  - a = 1, b = 0, SUB.
  - `pc_write` = 1 with pc_src = 1 iff (funct3 = 000 and `zero`) or (funct3 = 001 and !`zero`).
  - → FETCH.
- JAL: `reg_write`, mem_to_reg = 2, `pc_write`, pc_src = 1; → FETCH.
- HALT: `halted` = 1, all enables 0, remains until `rst`.
- instret:
  - Increments by 1 on every transition into FETCH from ALU_WB, MEM_WB, MEM_WR, BRANCH or JAL.
  - Wraps modulo 2^CNT_WIDTH.
  - HALT entries do not count.
- Latencies (rst low to instruction retirement):
  - R/I/LUI: 4 cycles.
  - ld: 5 + ack wait cycles.
  - sd: 4 + ack wait cycles.
  - beq/bne and jal: 3 cycles.

Test Plan:
- `rst` high 2 cycles then low, opcode = 0110011, funct3 = 0, funct7_5 = 1 → states 0,1,2,9,0; alu_op = 1 in EXEC_R; `reg_write` = 1 only in ALU_WB; `instret` = 1.
- ld (0000011/011) with `dmem_ack` arriving after 3 wait cycles → `dmem_read` high 4 cycles, `mdr_write` in the 4th only; MEM_WB mem_to_reg = 1; 8 cycles total.
- beq with zero = 1, then beq with zero = 0, then bne with zero = 0 → BRANCH `pc_write` = 1, 0, 1 respectively; each retires in 3 cycles.
- sd with `dmem_ack` held 0 and MEM_TIMEOUT = 4 → `dmem_write` high 4 cycles, then HALT, `err` = 2, `halted` = 1; `instret` unchanged; stays halted until `rst` clears `err` to 0.
- opcode 1111111 → HALT with `err` = 1. Then opcode 1110011 after reset → HALT with `err` = 0.
- `rst` asserted during MEM_RD wait → next cycle state = FETCH, `instret` = 0, no `mdr_write`/`reg_write` pulse.
